i2c_target_regfile: RTL and testbench
=====================================

# i2c_target_regfile

I2C target (responder) that accepts 3-byte codec-register write frames on a 2-wire bus and stores them in a 16 × 9-bit register file. It is the bus-side counterpart of the codec-initialisation master: it serves as the behavioural codec model in system benches and as a synthesizable configuration sink on the FPGA. SCL and SDA are oversampled by the system clock; no logic is clocked by SCL.

## Interface

Parameters:
- `DEV_ADDR`, default 7'h1A: 7-bit target address to ACK.
- `REG_DEPTH`, default 16: register-file entries; register addresses ≥ `REG_DEPTH` are ACKed but discarded.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `i_sclk`  in  1  bus SCL, asynchronous.
- `i_sdat`  in  1  bus SDA as read from the pad, asynchronous.
- `o_oen`  out  1  1 = pull SDA low (ACK); 0 = release.
- `o_wr_valid`  out  1  one-cycle strobe: a register write was committed.
- `o_wr_addr`  out  7  register address of the committed write.
- `o_wr_data`  out  9  data of the committed write.
- `i_rd_addr`  in  4  register-file read index.
- `o_rd_data`  out  9  combinational read of entry `i_rd_addr`.
- `o_busy`  out  1  1 from a detected START until a STOP or an ignored frame.
- `o_nack`  out  1  one-cycle strobe: address mismatch, or R/W = 1.

## Operation

- Input path: 2-flop synchroniser on SCL and SDA, then rise/fall edge detect on the synchronised values.
- START: synchronised SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in every state and take priority over bit sampling.
- Data bits are sampled on the SCL rising edge, MSB first.
- States: S_IDLE, S_ADDR, S_ACK_ADDR, S_BYTE_HI, S_ACK_HI, S_BYTE_LO, S_ACK_LO, S_IGNORE.
- Transitions:
  - START in any state → S_ADDR, bit counter cleared.
  - STOP in any state → S_IDLE.
  - S_ADDR: after 8 bits, if {addr[6:0], rw} = {`DEV_ADDR`, 0} → S_ACK_ADDR; otherwise pulse `o_nack` and go to S_IGNORE.
  - S_BYTE_HI: byte = {reg_addr[6:0], data[8]} → S_ACK_HI.
  - S_BYTE_LO: byte = data[7:0] → S_ACK_LO.
  - S_IGNORE: `o_oen` = 0 until START or STOP.
- ACK: `o_oen` asserts on the SCL falling edge after the 8th bit and deasserts on the following SCL falling edge. The state then advances S_ACK_ADDR → S_BYTE_HI, S_ACK_HI → S_BYTE_LO, S_ACK_LO → S_ADDR. A new address byte follows each 3-byte frame without a repeated START.
- Commit: on the SCL rising edge that samples the 8th bit of the low byte:
  - `o_wr_valid` = 1 for one cycle.
  - `o_wr_addr` / `o_wr_data` are updated and held until the next commit.
  - If reg_addr < `REG_DEPTH`, the register file is written.
  - Writing reg_addr 7'h0F clears the whole file to 0 instead of storing the data.
- A frame aborted by START or STOP before the commit edge writes nothing.
- Reset values: `o_oen` = 0, `o_wr_valid` = 0, `o_wr_addr` = 0, `o_wr_data` = 0, `o_busy` = 0, `o_nack` = 0, all registers 0, state S_IDLE.
- Reset mid-frame: immediate return to S_IDLE with SDA released; the next activity must begin with a START.

## Timing

- Latency from pad to edge detect: 2 `i_clk` cycles (4 with the filter).
- `o_oen` rises 1 cycle after the detected SCL falling edge.
- `o_wr_valid` rises 1 cycle after the detected SCL rising edge.
- Bus requirements: SCL high and low phases ≥ 4 `i_clk` cycles (≥ 6 with the filter); SDA stable ≥ 1 cycle either side of the SCL rising edge.
- SDA change and SCL edge detected in the same cycle: the SCL edge wins. No START/STOP is recognised that cycle.

## Configuration

- `I2C_TARGET_GLITCH_FILTER_EN` defined: each synchronised line passes through a 3-sample majority filter (2 extra cycles latency). Single-cycle pulses on SCL or SDA are suppressed.
- Not defined: the synchroniser output is used directly, and single-cycle glitches are seen as edges.

## Structure

- Package `i2c_target_pkg`: state enum, `DEV_ADDR_DEFAULT` (7'h1A), `REG_RESET_ADDR` (7'h0F), `REG_DEPTH_DEFAULT`.
- Sub-module `i2c_line_sync`: synchroniser, optional filter, and rise/fall edge flags for one line; instantiated twice.
- The top level holds the FSM, the shift register, the bit counter and the register file.

## Test plan

- START, 0x34, 0x08, 0x19, STOP → three ACKs; `o_wr_valid` pulse with addr 0x04, data 0x019; `o_rd_data`[4] = 0x019.
- Seven back-to-back 24-bit frames under one START (the full codec init sequence) → 7 commits in order; after the 0x0F frame all entries read 0 before the later writes land.
- Address byte 0x36 → no ACK, `o_nack` pulse, no commit; the next START with 0x34 is ACKed normally.
- STOP after the high byte → no commit, register file unchanged, `o_busy` = 0.
- `i_rst` asserted during S_ACK_HI → `o_oen` = 0 the next cycle; state S_IDLE; all registers 0.
- With the filter macro defined, a 1-cycle SCL low glitch mid-byte → no bit shifted, frame completes correctly.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C codec-register target.
// Optional feature macro used by this slice: I2C_TARGET_GLITCH_FILTER_EN.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_ADDR,
        S_BYTE_HI,
        S_ACK_HI,
        S_BYTE_LO,
        S_ACK_LO,
        S_IGNORE
    } state_e;

    localparam logic [6:0]  DEV_ADDR_DEFAULT  = 7'h1A;
    localparam logic [6:0]  REG_RESET_ADDR    = 7'h0F;
    localparam int unsigned REG_DEPTH_DEFAULT = 16;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// One bus line: 2-flop synchroniser, optional 3-sample majority filter
// (I2C_TARGET_GLITCH_FILTER_EN), and rise/fall flags on the clean level.
module i2c_line_sync
    import i2c_target_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] sync_q;
    logic       level;
    logic       prev_q;

    // Idle bus level is high, so reset to 1 to avoid phantom edges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], i_line};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hist_q <= '1;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
            filt_q <= maj3({hist_q, sync_q[1]});
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign o_level = level;
    assign o_rise  = level & ~prev_q;
    assign o_fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C write-only target: 3-byte frames {dev,w}/{reg,d8}/{d7:0} into a 16x9 register file.
// Build option I2C_TARGET_GLITCH_FILTER_EN enables the line majority filter.
module i2c_target_regfile
    import i2c_target_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR  = DEV_ADDR_DEFAULT,
    parameter int unsigned REG_DEPTH = REG_DEPTH_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_sdat,
    output logic       o_oen,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic       o_busy,
    output logic       o_nack
);

    localparam int unsigned DEPTH_CLAMP = (REG_DEPTH > 16) ? 16 : REG_DEPTH;
    localparam logic [7:0]  DEPTH_LIM   = 8'(DEPTH_CLAMP);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync u_scl (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_line  (i_sclk),
        .o_level (scl_lvl),
        .o_rise  (scl_rise),
        .o_fall  (scl_fall)
    );

    i2c_line_sync u_sda (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_line  (i_sdat),
        .o_level (sda_lvl),
        .o_rise  (sda_rise),
        .o_fall  (sda_fall)
    );

    state_e     state_q;
    logic [2:0] cnt_q;
    logic [7:0] sr_q;
    logic [6:0] reg_addr_q;
    logic       data8_q;
    logic       oen_q;
    logic       wr_valid_q;
    logic [6:0] wr_addr_q;
    logic [8:0] wr_data_q;
    logic       busy_q;
    logic       nack_q;
    logic [8:0] regs_q [16];

    logic       start_cond;
    logic       stop_cond;
    logic [7:0] shift_d;

    // An SCL edge in the same cycle masks any SDA-derived START/STOP.
    assign start_cond = sda_fall & scl_lvl & ~(scl_rise | scl_fall);
    assign stop_cond  = sda_rise & scl_lvl & ~(scl_rise | scl_fall);
    assign shift_d    = {sr_q[6:0], sda_lvl};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            reg_addr_q <= '0;
            data8_q    <= 1'b0;
            oen_q      <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            nack_q     <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_valid_q <= 1'b0;
            nack_q     <= 1'b0;
            if (start_cond) begin
                state_q <= S_ADDR;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                oen_q   <= 1'b0;
            end else if (stop_cond) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                oen_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_BYTE_HI, S_BYTE_LO: begin
                        if (scl_rise) begin
                            sr_q  <= shift_d;
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                case (state_q)
                                    S_ADDR: begin
                                        if (shift_d == {DEV_ADDR, 1'b0}) begin
                                            state_q <= S_ACK_ADDR;
                                        end else begin
                                            state_q <= S_IGNORE;
                                            nack_q  <= 1'b1;
                                            busy_q  <= 1'b0;
                                        end
                                    end
                                    S_BYTE_HI: begin
                                        reg_addr_q <= shift_d[7:1];
                                        data8_q    <= shift_d[0];
                                        state_q    <= S_ACK_HI;
                                    end
                                    default: begin
                                        wr_valid_q <= 1'b1;
                                        wr_addr_q  <= reg_addr_q;
                                        wr_data_q  <= {data8_q, shift_d};
                                        state_q    <= S_ACK_LO;
                                        if (reg_addr_q == REG_RESET_ADDR) begin
                                            for (int unsigned i = 0; i < 16; i++) begin
                                                regs_q[i] <= '0;
                                            end
                                        end else if ({1'b0, reg_addr_q} < DEPTH_LIM) begin
                                            regs_q[reg_addr_q[3:0]] <= {data8_q, shift_d};
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                    // First SCL fall after the 8th bit drives ACK, the next one releases it.
                    S_ACK_ADDR, S_ACK_HI, S_ACK_LO: begin
                        if (scl_fall) begin
                            if (!oen_q) begin
                                oen_q <= 1'b1;
                            end else begin
                                oen_q <= 1'b0;
                                cnt_q <= '0;
                                case (state_q)
                                    S_ACK_ADDR: state_q <= S_BYTE_HI;
                                    S_ACK_HI:   state_q <= S_BYTE_LO;
                                    default:    state_q <= S_ADDR;
                                endcase
                            end
                        end
                    end
                    S_IGNORE: begin
                        oen_q <= 1'b0;
                    end
                    default: begin
                        oen_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_oen      = oen_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_busy     = busy_q;
    assign o_nack     = nack_q;
    assign o_rd_data  = regs_q[i_rd_addr];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Self-checking bench: bus-master tasks, commit scoreboard, table-driven codec init frames.
module tb_i2c_target_regfile;
    import i2c_target_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sdat;
    logic       oen, wr_valid, busy, nack;
    logic [6:0] wr_addr;
    logic [8:0] wr_data, rd_data;
    logic [3:0] rd_addr;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int nack_seen = 0;

    typedef struct {
        logic [6:0] addr;
        logic [8:0] data;
    } frame_t;

    frame_t     exp_q[$];
    logic [8:0] model [16];

    always #5 clk = ~clk;

    // Open-drain bus: target ACK pulls SDA low.
    assign sdat = sda_m & ~oen;

    i2c_target_regfile #(.DEV_ADDR(7'h1A), .REG_DEPTH(16)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_sclk     (scl_m),
        .i_sdat     (sdat),
        .o_oen      (oen),
        .o_wr_valid (wr_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_busy     (busy),
        .o_nack     (nack)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nack) nack_seen++;
        if (wr_valid) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL unexpected_commit: got addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
            end else begin
                frame_t e;
                e = exp_q.pop_front();
                check("commit_addr", 32'(wr_addr), 32'(e.addr));
                check("commit_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        wait_clk(4);
        sda_m = b;
        wait_clk(4);
        scl_m = 1'b1;
        if (glitch) begin
            wait_clk(3);
            scl_m = 1'b0;
            wait_clk(1);
            scl_m = 1'b1;
            wait_clk(4);
        end else begin
            wait_clk(8);
        end
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit exp_ack, input int glitch_bit, input string tag);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(4);
        check({tag, "_ack"}, 32'(sdat), 32'(!exp_ack));
        wait_clk(4);
        scl_m = 1'b0;
        wait_clk(6);
        check({tag, "_release"}, 32'(oen), 32'd0);
    endtask

    task automatic start_cond();
        wait_clk(4);
        sda_m = 1'b1;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(8);
        sda_m = 1'b0;
        wait_clk(8);
        scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(8);
        sda_m = 1'b1;
        wait_clk(8);
    endtask

    task automatic expect_commit(input logic [6:0] a, input logic [8:0] d);
        frame_t f;
        f.addr = a;
        f.data = d;
        exp_q.push_back(f);
        if (a == 7'h0F) begin
            for (int i = 0; i < 16; i++) model[i] = '0;
        end else if (a < 7'd16) begin
            model[a[3:0]] = d;
        end
    endtask

    task automatic send_regs(input logic [6:0] a, input logic [8:0] d, input int glitch_bit);
        write_byte({a, d[8]}, 1'b1, -1, "hi");
        expect_commit(a, d);
        write_byte(d[7:0], 1'b1, glitch_bit, "lo");
    endtask

    task automatic check_reg(input int i);
        @(negedge clk);
        rd_addr = 4'(i);
        #1;
        check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(model[i]));
    endtask

    task automatic check_all_regs();
        for (int i = 0; i < 16; i++) check_reg(i);
    endtask

    frame_t tbl[7];

    initial begin
        tbl[0] = '{7'h0F, 9'h000};
        tbl[1] = '{7'h06, 9'h000};
        tbl[2] = '{7'h00, 9'h017};
        tbl[3] = '{7'h02, 9'h179};
        tbl[4] = '{7'h04, 9'h012};
        tbl[5] = '{7'h07, 9'h04A};
        tbl[6] = '{7'h09, 9'h001};
        for (int i = 0; i < 16; i++) model[i] = '0;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr = '0;
        wait_clk(3);
        rst = 1'b0;
        #1;
        check("rst_oen", 32'(oen), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_nack", 32'(nack), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        wait_clk(4);

        // Single frame: reg 4 <= 0x019.
        start_cond();
        check("busy_after_start", 32'(busy), 32'd1);
        write_byte(8'h34, 1'b1, -1, "addr");
        send_regs(7'h04, 9'h019, -1);
        stop_cond();
        check("busy_after_stop", 32'(busy), 32'd0);
        check_reg(4);

        // Codec init table: seven frames back to back under one START.
        start_cond();
        for (int i = 0; i < 7; i++) begin
            write_byte(8'h34, 1'b1, -1, "tbl_addr");
            send_regs(tbl[i].addr, tbl[i].data, -1);
            if (tbl[i].addr == 7'h0F) check_all_regs();
            else check_reg(int'(tbl[i].addr));
        end
        stop_cond();
        check_all_regs();
        check("tbl_drained", 32'(exp_q.size()), 32'd0);

        // Wrong device address: ignored, nack pulse, then normal frame.
        begin
            int n0;
            n0 = nack_seen;
            start_cond();
            write_byte(8'h36, 1'b0, -1, "bad_addr");
            check("nack_pulse", 32'(nack_seen - n0), 32'd1);
            check("busy_ignore", 32'(busy), 32'd0);
            write_byte(8'h08, 1'b0, -1, "ign_hi");
            write_byte(8'h55, 1'b0, -1, "ign_lo");
            stop_cond();
            start_cond();
            write_byte(8'h34, 1'b1, -1, "addr");
            send_regs(7'h03, 9'h0AA, -1);
            stop_cond();
            check_reg(3);
        end

        // STOP after the high byte: nothing committed.
        start_cond();
        write_byte(8'h34, 1'b1, -1, "addr");
        write_byte({7'h05, 1'b1}, 1'b1, -1, "abort_hi");
        stop_cond();
        check("busy_abort", 32'(busy), 32'd0);
        check_all_regs();

        // Register address beyond depth: commit strobe, file untouched.
        start_cond();
        write_byte(8'h34, 1'b1, -1, "addr");
        send_regs(7'h20, 9'h155, -1);
        stop_cond();
        check_all_regs();
        check("oob_drained", 32'(exp_q.size()), 32'd0);

        // Reset while driving the high-byte ACK.
        start_cond();
        write_byte(8'h34, 1'b1, -1, "addr");
        for (int i = 7; i >= 0; i--) send_bit(i[0], 1'b0);
        sda_m = 1'b1;
        begin
            int t;
            t = 0;
            while (!oen && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("ack_hi_seen", 32'(oen), 32'd1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_oen", 32'(oen), 32'd0);
        check("rst_mid_state", 32'(dut.state_q), 32'(S_IDLE));
        check("rst_mid_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 16; i++) model[i] = '0;
        check_all_regs();
        wait_clk(4);
        scl_m = 1'b1;
        wait_clk(8);
        scl_m = 1'b0;
        write_byte(8'h34, 1'b0, -1, "no_start");
        stop_cond();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // One-cycle SCL dips inside the address and low bytes are filtered.
        start_cond();
        write_byte(8'h34, 1'b1, 5, "glitch_addr");
        send_regs(7'h0A, 9'h133, 3);
        stop_cond();
        check_reg(10);
`endif

        wait_clk(10);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
